// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus a WIDTH-step
// shift-add multiplier, with registered result/flags and a done pulse.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alus,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] dout,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_DEC  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_ZERO = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_PASS = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_ROL  = 4'b1101;
  localparam logic [3:0] OP_SAR  = 4'b1110;
  localparam logic [3:0] OP_ILL  = 4'b1111;

  // Two's-complement overflow from operand/result sign bits.
  function automatic logic add_ovf(input logic a_s, input logic b_s, input logic r_s);
    return (a_s == b_s) && (r_s != a_s);
  endfunction

  function automatic logic sub_ovf(input logic a_s, input logic b_s, input logic r_s);
    return (a_s != b_s) && (r_s != a_s);
  endfunction

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       dout_q, dout_d;
  logic                   z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;
  logic                   err_q, err_d;
  logic [2*WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [2*WIDTH-1:0]     prod_q, prod_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [WIDTH-1:0]       alu_res;
  logic                   alu_c, alu_v;
  logic signed [WIDTH-1:0] rhs;
  logic [WIDTH:0]         add_w, sub_w;
  logic [2*WIDTH-1:0]     prod_nxt;

  // Combinational single-cycle datapath
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    rhs     = ((alus == OP_INC) || (alus == OP_DEC)) ? WIDTH'(1) : bus;
    add_w   = {1'b0, x} + {1'b0, rhs};
    sub_w   = {1'b0, x} - {1'b0, rhs};
    case (alus)
      OP_ADD, OP_INC: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = add_ovf(x[WIDTH-1], rhs[WIDTH-1], add_w[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = sub_ovf(x[WIDTH-1], rhs[WIDTH-1], sub_w[WIDTH-1]);
      end
      OP_AND:  alu_res = x & bus;
      OP_OR:   alu_res = x | bus;
      OP_XOR:  alu_res = x ^ bus;
      OP_NOT:  alu_res = ~x;
      OP_ZERO: alu_res = '0;
      OP_SHL: begin
        alu_res = {x[WIDTH-2:0], 1'b0};
        alu_c   = x[WIDTH-1];
      end
      OP_PASS: alu_res = bus;
      OP_SHR: begin
        alu_res = {1'b0, x[WIDTH-1:1]};
        alu_c   = x[0];
      end
      OP_ROL: begin
        alu_res = {x[WIDTH-2:0], x[WIDTH-1]};
        alu_c   = x[WIDTH-1];
      end
      OP_SAR: begin
        alu_res = {x[WIDTH-1], x[WIDTH-1:1]};
        alu_c   = x[0];
      end
      default: ;
    endcase
  end

  // Next-state and register-update logic
  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    z_d      = z_q;
    c_d      = c_q;
    n_d      = n_q;
    v_d      = v_q;
    err_d    = err_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (alus == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, x};
            mplier_d = bus;
            prod_d   = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else if (alus == OP_ILL) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            dout_d  = alu_res;
            z_d     = (alu_res == '0);
            c_d     = alu_c;
            n_d     = alu_res[WIDTH-1];
            v_d     = alu_v;
            err_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      MUL: begin
        prod_d   = prod_nxt;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        // Last step: publish the product computed this cycle.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          dout_d  = prod_nxt[WIDTH-1:0];
          z_d     = (prod_nxt[WIDTH-1:0] == '0);
          c_d     = |prod_nxt[2*WIDTH-1:WIDTH];
          n_d     = prod_nxt[WIDTH-1];
          v_d     = 1'b0;
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dout_q   <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      err_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      z_q      <= z_d;
      c_q      <= c_d;
      n_q      <= n_d;
      v_q      <= v_d;
      err_q    <= err_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout   = dout_q;
  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_n = n_q;
  assign flag_v = v_q;
  assign busy   = (state_q == MUL);
  assign done   = (state_q == DONE);
  assign err    = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (WIDTH=8) with hand-computed expectations.
module tb_alu_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] alus;
  logic [7:0] x, bus;
  logic [7:0] dout;
  logic       flag_z, flag_c, flag_n, flag_v, busy, done, err;

  int n_checks = 0;
  int n_errors = 0;
  int lat, bsy, dones;
  logic [7:0] dout_at_done;

  alu_mc #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alus(alus), .x(x), .bus(bus),
    .dout(dout), .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
    .flag_v(flag_v), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the FSM idle; returns at the negedge after done.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    alus = op; x = a; bus = b; start = 1'b1;
    lat = 0; bsy = 0;
    forever begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) bsy++;
      if (done || lat > 40) break;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic after_done();
    @(negedge clk);
    chk("done_single_pulse", {31'd0, done}, 32'd0);
  endtask

  // {z,c,n,v}
  function automatic logic [3:0] flags();
    return {flag_z, flag_c, flag_n, flag_v};
  endfunction

  task automatic op_check(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_d, input logic [3:0] exp_f);
    run_op(op, a, b);
    chk({tag, "_dout"}, dout, exp_d);
    chk({tag, "_flags"}, flags(), exp_f);
    chk({tag, "_err"}, err, 0);
    after_done();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; alus = '0; x = '0; bus = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_flags", flags(), 0);
    chk("rst_ctrl", {busy, done, err}, 0);
    rst_n = 1'b1;

    // add FF+01
    run_op(4'b0000, 8'hFF, 8'h01);
    chk("add_lat", lat, 1);
    chk("add_dout", dout, 8'h00);
    chk("add_flags", flags(), 4'b1100);
    chk("add_err", err, 0);
    after_done();

    op_check("sub_80_01", 4'b0001, 8'h80, 8'h01, 8'h7F, 4'b0001);
    op_check("sub_00_01", 4'b0001, 8'h00, 8'h01, 8'hFF, 4'b0110);
    op_check("and",  4'b0010, 8'hF0, 8'h3C, 8'h30, 4'b0000);
    op_check("or",   4'b0011, 8'hA0, 8'h05, 8'hA5, 4'b0010);
    op_check("xor",  4'b0100, 8'hFF, 8'h0F, 8'hF0, 4'b0010);
    op_check("inc",  4'b0101, 8'h7F, 8'h00, 8'h80, 4'b0011);
    op_check("dec",  4'b0110, 8'h00, 8'h00, 8'hFF, 4'b0110);
    op_check("not",  4'b0111, 8'h55, 8'h00, 8'hAA, 4'b0010);
    op_check("zero", 4'b1000, 8'h55, 8'h66, 8'h00, 4'b1000);
    op_check("shl",  4'b1001, 8'h81, 8'h00, 8'h02, 4'b0100);
    op_check("pass", 4'b1010, 8'h11, 8'h3C, 8'h3C, 4'b0000);
    op_check("shr",  4'b1100, 8'h81, 8'h00, 8'h40, 4'b0100);
    op_check("rol",  4'b1101, 8'h81, 8'h00, 8'h03, 4'b0100);
    op_check("sar",  4'b1110, 8'h81, 8'h00, 8'hC0, 4'b0110);

    // multiply 0F*11
    run_op(4'b1011, 8'h0F, 8'h11);
    chk("mul1_lat", lat, 9);
    chk("mul1_busy_cycles", bsy, 8);
    chk("mul1_dout", dout, 8'hFF);
    chk("mul1_flags", flags(), 4'b0010);
    chk("mul1_err", err, 0);
    after_done();

    op_check("mul_10_10", 4'b1011, 8'h10, 8'h10, 8'h00, 4'b1100);

    // multiply with a competing add request injected mid-flight
    alus = 4'b1011; x = 8'h0F; bus = 8'h11; start = 1'b1;
    dones = 0; lat = 0; dout_at_done = '0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      start = (i == 3);
      if (i == 3) begin alus = 4'b0000; x = 8'h01; bus = 8'h01; end
      if (done) begin dones++; lat = i; dout_at_done = dout; end
    end
    chk("mulint_dones", dones, 1);
    chk("mulint_lat", lat, 9);
    chk("mulint_dout", dout_at_done, 8'hFF);

    // reset asserted mid-multiply
    alus = 4'b1011; x = 8'h0F; bus = 8'h11; start = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("rstmul_busy_before", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmul_dout", dout, 0);
    chk("rstmul_flags", flags(), 0);
    chk("rstmul_ctrl", {busy, done, err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("rstmul_no_activity", dones, 0);

    op_check("add_2_3", 4'b0000, 8'h02, 8'h03, 8'h05, 4'b0000);

    // illegal opcode holds result/flags
    run_op(4'b1111, 8'hAA, 8'h55);
    chk("ill1_dout", dout, 8'h05);
    chk("ill1_flags", flags(), 4'b0000);
    chk("ill1_err", err, 1);
    after_done();
    op_check("sub_after_ill", 4'b0001, 8'h00, 8'h01, 8'hFF, 4'b0110);
    run_op(4'b1111, 8'h00, 8'h00);
    chk("ill2_dout", dout, 8'hFF);
    chk("ill2_flags", flags(), 4'b0110);
    chk("ill2_err", err, 1);
    after_done();
    op_check("legal_after_ill", 4'b1010, 8'h00, 8'h42, 8'h42, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand/result width (legal range 4..32).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request one operation; sampled only in IDLE.
REQ-005 alus  input  4  SHALL select the operation (REQ-012).
REQ-006 x  input  WIDTH  SHALL be operand A (accumulator side).
REQ-007 bus  input  WIDTH  SHALL be operand B (data bus side).
REQ-008 dout  output  WIDTH  SHALL be the registered result, held until the next completed operation.
REQ-009 flag_z, flag_c, flag_n, flag_v  output  1 each  SHALL be the registered zero, carry/borrow, negative and signed-overflow flags, updated with dout.
REQ-010 busy  output  1  SHALL be high while a multi-cycle operation is in progress.
REQ-011 done  output  1  SHALL be a single-cycle pulse marking completion; err  output  1  SHALL flag an illegal opcode and be valid while done is high.

Function
REQ-012 Opcodes: 0000 x+bus; 0001 x-bus; 0010 AND; 0011 OR; 0100 XOR; 0101 x+1; 0110 x-1; 0111 ~x; 1000 zero; 1001 x<<1; 1010 pass bus; 1011 x*bus (low WIDTH bits, multi-cycle); 1100 x>>1 logical; 1101 rotate-left x by 1; 1110 x>>>1 arithmetic; 1111 illegal.
REQ-013 FSM states: IDLE, MUL, DONE; reset state IDLE.
REQ-014 IDLE with start=1 and any opcode other than 1011 SHALL register the result and flags on that edge, then enter DONE.
REQ-015 IDLE with start=1 and alus=1011 SHALL capture x and bus into internal registers, clear the product and count, and enter MUL; busy=1 from the next cycle.
REQ-016 MUL SHALL perform one shift-add step per clock for exactly WIDTH clocks, then register the product and flags and enter DONE; busy SHALL drop on that same edge.
REQ-017 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE; a start seen in DONE SHALL be ignored.
REQ-018 Latency: single-cycle ops SHALL raise done 1 cycle after the start edge; multiply SHALL raise done WIDTH+1 cycles after the start edge.
REQ-019 start, alus, x and bus changes while busy=1 SHALL have no effect on the operation in flight.
REQ-020 flag_z = (dout==0); flag_n = dout[WIDTH-1] for all legal ops.
REQ-021 flag_c: add/inc = carry out of bit WIDTH-1; sub/dec = borrow (1 when unsigned subtrahend > minuend); shl/rol = old x[WIDTH-1]; shr/sar = old x[0]; mul = 1 if any of the upper WIDTH product bits is nonzero; all other ops 0.
REQ-022 flag_v: add/inc/sub/dec = two's-complement signed overflow; all other ops 0.
REQ-023 alus=1111 SHALL leave dout and all flags unchanged, set err=1 and still complete via DONE; err SHALL be 0 for every legal op.
REQ-024 All arithmetic SHALL wrap modulo 2^WIDTH; no X SHALL ever appear on outputs.

Reset
REQ-025 rst_n low SHALL immediately force dout=0, all flags=0, busy=0, done=0, err=0, FSM=IDLE, and clear internal operand, product and count registers, including mid-multiply.
REQ-026 After rst_n rises, the first start SHALL be accepted on the first rising clock edge at which it is high.

Verification (WIDTH=8)
REQ-027 add 0xFF+0x01 -> dout=0x00, z=1, c=1, v=0, done 1 cycle after start.
REQ-028 sub 0x80-0x01 -> dout=0x7F, v=1, c=0, n=0; sub 0x00-0x01 -> dout=0xFF, c=1, n=1.
REQ-029 mul 0x0F*0x11 -> dout=0xFF, c=0, busy for 8 cycles, done at cycle 9; mul 0x10*0x10 -> dout=0x00, z=1, c=1.
REQ-030 mul started, then start with add and new operands pulsed at cycle 3 -> ignored; multiply result unchanged, exactly one done.
REQ-031 rst_n asserted at cycle 4 of a multiply -> all outputs 0 at once, no done; a new add 0x02+0x03 afterwards -> dout=0x05.
REQ-032 Opcode 1111 after a result of 0x05 -> dout stays 0x05, flags unchanged, err=1 with done; next legal op -> err=0.
